parking_controller: RTL and testbench
=====================================

Name: parking_controller

Overview:
- Parametrised next-generation gate controller for the car-park entry lane.
- Runs the password-gated entry FSM and tracks lot occupancy against a configurable capacity.
- Refuses entry when the lot is full and drives blink-rate-controlled LEDs plus two active-low 7-segment digits.
- Sits between the lane sensors/keypad and the board LEDs/HEX displays.

Parameters:
- PW_W, 2, width of each password field
- PASS_1, 2'b01, required value of password_1
- PASS_2, 2'b10, required value of password_2
- CAPACITY, 8, number of parking spaces
- CNT_W, 4, occupancy counter width; must hold CAPACITY
- WAIT_CYCLES, 4, length of the password entry window in clocks (minimum 1)
- BLINK_DIV, 1, clocks per blinking-LED toggle (minimum 1)
- MAX_TRIES, 3, failed attempts before lockout (feature only)
- LOCK_CYCLES, 16, lockout duration in clocks (feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sensor_entrance  in  1  car present at entry gate (level)
- sensor_exit  in  1  car passing exit sensor (level)
- password_1  in  PW_W  keypad field 1
- password_2  in  PW_W  keypad field 2
- GREEN_LED  out  1  registered
- RED_LED  out  1  registered
- HEX_1  out  7  registered, active-low gfedcba
- HEX_2  out  7  registered, active-low gfedcba
- occupancy  out  CNT_W  cars currently in the lot
- full  out  1  occupancy == CAPACITY

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE; all internal counters 0; occupancy 0.
  - GREEN_LED 0, RED_LED 0, HEX_1 7'h7F, HEX_2 7'h7F, full 0.
  - exit_d cleared to 0, so a held sensor_exit after reset produces no pulse.
  - Reset mid-operation aborts immediately and clears the occupancy count.
- exit_pulse = sensor_exit & ~exit_d, where exit_d is sensor_exit registered once.
- match = (password_1==PASS_1) && (password_2==PASS_2).
- States and transitions (priority top-down within each state):
  - IDLE:
    - sensor_entrance and full -> FULL.
    - sensor_entrance -> WAIT_PASSWORD.
  - WAIT_PASSWORD:
    - wait_cnt increments each cycle.
    - At wait_cnt==WAIT_CYCLES-1, sample: match -> RIGHT_PASS, else -> WRONG_PASS.
  - WRONG_PASS: match -> RIGHT_PASS, else stay.
  - RIGHT_PASS:
    - sensor_entrance & sensor_exit in the same cycle (tailgate) -> STOP.
    - exit_pulse -> IDLE and occupancy+1.
  - STOP: match -> RIGHT_PASS, else stay.
  - FULL: ~sensor_entrance or ~full -> IDLE.
- Occupancy:
  - exit_pulse in any state other than RIGHT_PASS means a car leaving the lot: occupancy-1.
  - Saturates at 0 and at CAPACITY; increments and decrements beyond those limits are dropped.
  - An exit_pulse that coincides with a tailgate is ignored; only the STOP transition occurs.
- Outputs:
  - Registered from current_state, so each output changes one clock after state entry.
  - IDLE: LEDs 0/0; HEX off/off.
  - WAIT_PASSWORD: red 1; HEX "E","n" (0000110, 0101011).
  - WRONG_PASS: red blinks; HEX "E","E".
  - RIGHT_PASS: green blinks; HEX "6","0" (0000010, 1000000).
  - STOP: red blinks; HEX "5","P" (0010010, 0001100).
  - FULL: red 1 steady; HEX "F","L" (0001110, 1000111).
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; the LED toggles on wrap.
  - On any state change, blink_cnt and the blinking LED phase restart at 0.
  - The LED not blinking in a state is driven 0.
- wait_cnt clears on every state change.
- full is combinational from the occupancy register.

Optional Feature:
- Macro: PARKING_LOCKOUT_EN.
- Defined:
  - Adds a fail_cnt register and a LOCKOUT state.
  - Each mismatched sample increments fail_cnt. Samples occur at the WAIT_PASSWORD window end, and in WRONG_PASS at every WAIT_CYCLES-cycle window end.
  - In WRONG_PASS, a match at the window end -> RIGHT_PASS; match between window ends is ignored.
  - When fail_cnt reaches MAX_TRIES -> LOCKOUT.
  - LOCKOUT: red 1, HEX "L","0". All inputs are ignored except exit_pulse for occupancy. After LOCK_CYCLES clocks -> IDLE.
  - fail_cnt clears on entering RIGHT_PASS or IDLE.
- Not defined:
  - No fail_cnt and no LOCKOUT state.
  - WRONG_PASS evaluates match every cycle, as described above.

Test Plan:
- Reset, entrance=1, correct password held -> WAIT_PASSWORD for 4 clocks; RIGHT_PASS entered on clock 5; HEX 0000010/1000000 one clock later.
- RIGHT_PASS, sensor_exit 0->1 -> IDLE; occupancy 0->1. Hold sensor_exit high 5 cycles -> exactly one increment.
- Wrong password (2'b00, 2'b00), then correct value -> WRONG_PASS, red toggling every clock (BLINK_DIV=1); RIGHT_PASS on the cycle after the correct value.
- RIGHT_PASS, entrance and exit asserted together -> STOP, HEX 0010010/0001100; correct password -> RIGHT_PASS; occupancy unchanged.
- CAPACITY=2, admit 2 cars -> full=1; entrance -> FULL, HEX "FL". One exit pulse -> occupancy 1, full=0, FULL -> IDLE. Exit pulses at 0 -> occupancy stays 0.
- With PARKING_LOCKOUT_EN, MAX_TRIES=3, wrong password held -> LOCKOUT after the 3rd failed window; IDLE exactly 16 clocks later; reset asserted mid-LOCKOUT -> IDLE, occupancy 0.

Source files
------------

// File: rtl/parking_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : parking_controller_if                                         |
// | Purpose  : Lane-side bundle for the parking gate controller: sensor and  |
// |            keypad inputs, LED/HEX drive and occupancy status.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface parking_controller_if #(
  parameter int PW_W  = 2,
  parameter int CNT_W = 4
);
  logic             sensor_entrance;
  logic             sensor_exit;
  logic [PW_W-1:0]  password_1;
  logic [PW_W-1:0]  password_2;
  logic             GREEN_LED;
  logic             RED_LED;
  logic [6:0]       HEX_1;
  logic [6:0]       HEX_2;
  logic [CNT_W-1:0] occupancy;
  logic             full;

  // Lane side: drives sensors and keypad, observes the indicators.
  modport master (
    output sensor_entrance, sensor_exit, password_1, password_2,
    input  GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full
  );

  // Controller side.
  modport slave (
    input  sensor_entrance, sensor_exit, password_1, password_2,
    output GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full
  );
endinterface
`default_nettype wire

// File: rtl/parking_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : parking_controller                                            |
// | Purpose  : Password-gated car-park entry FSM with occupancy tracking,    |
// |            full-lot refusal, blinking LEDs and two active-low HEX digits.|
// | Options  : define PARKING_LOCKOUT_EN to add failed-attempt lockout.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module parking_controller #(
  parameter int              PW_W        = 2,
  parameter logic [PW_W-1:0] PASS_1      = 'b01,
  parameter logic [PW_W-1:0] PASS_2      = 'b10,
  parameter int              CAPACITY    = 8,
  parameter int              CNT_W       = 4,
  parameter int              WAIT_CYCLES = 4,
  parameter int              BLINK_DIV   = 1,
  parameter int              MAX_TRIES   = 3,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  parking_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_PASSWORD = 3'd1,
    ST_WRONG_PASS    = 3'd2,
    ST_RIGHT_PASS    = 3'd3,
    ST_STOP          = 3'd4,
    ST_FULL          = 3'd5
`ifdef PARKING_LOCKOUT_EN
    , ST_LOCKOUT     = 3'd6
`endif
  } state_t;

  // One dwell counter serves both the password window and the lockout timer.
`ifdef PARKING_LOCKOUT_EN
  localparam int c_dwell_max = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
`else
  localparam int c_dwell_max = WAIT_CYCLES;
`endif
  localparam int c_dwell_w = $clog2(c_dwell_max + 1);
  localparam logic [c_dwell_w-1:0] c_wait_last = c_dwell_w'(WAIT_CYCLES - 1);
  localparam logic [c_dwell_w-1:0] c_dwell_one = c_dwell_w'(1);

  localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
  localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);

  localparam logic [CNT_W-1:0] c_capacity = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] c_occ_one  = CNT_W'(1);

  // Active-low gfedcba glyphs.
  localparam logic [6:0] c_seg_off = 7'h7F;
  localparam logic [6:0] c_seg_e   = 7'b0000110;
  localparam logic [6:0] c_seg_n   = 7'b0101011;
  localparam logic [6:0] c_seg_6   = 7'b0000010;
  localparam logic [6:0] c_seg_0   = 7'b1000000;
  localparam logic [6:0] c_seg_5   = 7'b0010010;
  localparam logic [6:0] c_seg_p   = 7'b0001100;
  localparam logic [6:0] c_seg_f   = 7'b0001110;
  localparam logic [6:0] c_seg_l   = 7'b1000111;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_exit_d;
  logic [CNT_W-1:0]       r_occupancy;
  logic [c_dwell_w-1:0]   r_wait_cnt;
  logic [c_blink_w-1:0]   r_blink_cnt;
  logic                   r_blink_phase;
  logic                   r_green;
  logic                   r_red;
  logic [6:0]             r_hex_1;
  logic [6:0]             r_hex_2;

  logic w_exit_pulse;
  logic w_match;
  logic w_full;
  logic w_window_end;
  logic w_state_change;
  logic w_occ_inc;
  logic w_occ_dec;

`ifdef PARKING_LOCKOUT_EN
  localparam int c_fail_w = $clog2(MAX_TRIES + 1);
  localparam logic [c_fail_w-1:0] c_fail_limit = c_fail_w'(MAX_TRIES - 1);
  localparam logic [c_fail_w-1:0] c_fail_one   = c_fail_w'(1);
  localparam logic [c_dwell_w-1:0] c_lock_last = c_dwell_w'(LOCK_CYCLES - 1);
  logic [c_fail_w-1:0] r_fail_cnt;
  logic                w_fail_inc;
  logic                w_fail_limit;
  // A mismatch seen with MAX_TRIES-1 failures already logged is the last straw.
  assign w_fail_limit = (r_fail_cnt >= c_fail_limit);
`else
  logic [63:0] w_unused_cfg;
  assign w_unused_cfg = {32'(MAX_TRIES), 32'(LOCK_CYCLES)};
`endif

  assign w_exit_pulse   = bus.sensor_exit & ~r_exit_d;
  assign w_match        = (bus.password_1 == PASS_1) && (bus.password_2 == PASS_2);
  assign w_full         = (r_occupancy == c_capacity);
  assign w_window_end   = (r_wait_cnt == c_wait_last);
  assign w_state_change = (w_next_state != r_state);

  // Next-state selection and occupancy requests.
  always_comb begin
    w_next_state = r_state;
    w_occ_inc    = 1'b0;
    w_occ_dec    = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    w_fail_inc   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (bus.sensor_entrance && w_full) w_next_state = ST_FULL;
        else if (bus.sensor_entrance)      w_next_state = ST_WAIT_PASSWORD;
      end
      ST_WAIT_PASSWORD: begin
        if (w_window_end) begin
          if (w_match) begin
            w_next_state = ST_RIGHT_PASS;
          end else begin
`ifdef PARKING_LOCKOUT_EN
            w_fail_inc   = 1'b1;
            w_next_state = w_fail_limit ? ST_LOCKOUT : ST_WRONG_PASS;
`else
            w_next_state = ST_WRONG_PASS;
`endif
          end
        end
      end
      ST_WRONG_PASS: begin
`ifdef PARKING_LOCKOUT_EN
        if (w_window_end) begin
          if (w_match) begin
            w_next_state = ST_RIGHT_PASS;
          end else begin
            w_fail_inc = 1'b1;
            if (w_fail_limit) w_next_state = ST_LOCKOUT;
          end
        end
`else
        if (w_match) w_next_state = ST_RIGHT_PASS;
`endif
      end
      ST_RIGHT_PASS: begin
        // Tailgate wins; any exit edge seen alongside it is not counted.
        if (bus.sensor_entrance && bus.sensor_exit) begin
          w_next_state = ST_STOP;
        end else if (w_exit_pulse) begin
          w_next_state = ST_IDLE;
          w_occ_inc    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_match) w_next_state = ST_RIGHT_PASS;
      end
      ST_FULL: begin
        if (!bus.sensor_entrance || !w_full) w_next_state = ST_IDLE;
      end
`ifdef PARKING_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (r_wait_cnt == c_lock_last) w_next_state = ST_IDLE;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
    // Outside RIGHT_PASS an exit edge is a car leaving the lot.
    if (w_exit_pulse && (r_state != ST_RIGHT_PASS)) w_occ_dec = 1'b1;
  end

  // State, counters, occupancy and registered indicator outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_exit_d      <= 1'b0;
      r_occupancy   <= '0;
      r_wait_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_green       <= 1'b0;
      r_red         <= 1'b0;
      r_hex_1       <= c_seg_off;
      r_hex_2       <= c_seg_off;
`ifdef PARKING_LOCKOUT_EN
      r_fail_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_exit_d <= bus.sensor_exit;

      if (w_occ_inc && (r_occupancy != c_capacity))
        r_occupancy <= r_occupancy + c_occ_one;
      else if (w_occ_dec && (r_occupancy != '0))
        r_occupancy <= r_occupancy - c_occ_one;

      if (w_state_change)
        r_wait_cnt <= '0;
      else if (r_state == ST_WAIT_PASSWORD)
        r_wait_cnt <= r_wait_cnt + c_dwell_one;
`ifdef PARKING_LOCKOUT_EN
      else if (r_state == ST_WRONG_PASS)
        r_wait_cnt <= w_window_end ? '0 : r_wait_cnt + c_dwell_one;
      else if (r_state == ST_LOCKOUT)
        r_wait_cnt <= r_wait_cnt + c_dwell_one;

      if ((w_next_state == ST_RIGHT_PASS) || (w_next_state == ST_IDLE))
        r_fail_cnt <= '0;
      else if (w_fail_inc)
        r_fail_cnt <= r_fail_cnt + c_fail_one;
`endif

      if (w_state_change) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + c_blink_one;
      end

      unique case (r_state)
        ST_WAIT_PASSWORD: begin
          r_green <= 1'b0;          r_red <= 1'b1;
          r_hex_1 <= c_seg_e;       r_hex_2 <= c_seg_n;
        end
        ST_WRONG_PASS: begin
          r_green <= 1'b0;          r_red <= r_blink_phase;
          r_hex_1 <= c_seg_e;       r_hex_2 <= c_seg_e;
        end
        ST_RIGHT_PASS: begin
          r_green <= r_blink_phase; r_red <= 1'b0;
          r_hex_1 <= c_seg_6;       r_hex_2 <= c_seg_0;
        end
        ST_STOP: begin
          r_green <= 1'b0;          r_red <= r_blink_phase;
          r_hex_1 <= c_seg_5;       r_hex_2 <= c_seg_p;
        end
        ST_FULL: begin
          r_green <= 1'b0;          r_red <= 1'b1;
          r_hex_1 <= c_seg_f;       r_hex_2 <= c_seg_l;
        end
`ifdef PARKING_LOCKOUT_EN
        ST_LOCKOUT: begin
          r_green <= 1'b0;          r_red <= 1'b1;
          r_hex_1 <= c_seg_l;       r_hex_2 <= c_seg_0;
        end
`endif
        default: begin
          r_green <= 1'b0;          r_red <= 1'b0;
          r_hex_1 <= c_seg_off;     r_hex_2 <= c_seg_off;
        end
      endcase
    end
  end

  assign bus.GREEN_LED = r_green;
  assign bus.RED_LED   = r_red;
  assign bus.HEX_1     = r_hex_1;
  assign bus.HEX_2     = r_hex_2;
  assign bus.occupancy = r_occupancy;
  assign bus.full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_parking_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_parking_controller                                         |
// | Purpose  : Directed and randomized bench for parking_controller against |
// |            a dwell-time based behavioural model of the gate.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_parking_controller;

  localparam int              PW_W        = 2;
  localparam logic [PW_W-1:0] PASS_1      = 2'b01;
  localparam logic [PW_W-1:0] PASS_2      = 2'b10;
  localparam int              CAPACITY    = 2;
  localparam int              CNT_W       = 4;
  localparam int              WAIT_CYCLES = 4;
  localparam int              BLINK_DIV   = 1;
  localparam int              MAX_TRIES   = 3;
  localparam int              LOCK_CYCLES = 16;
  localparam logic [PW_W-1:0] BAD         = '0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_controller_if #(.PW_W(PW_W), .CNT_W(CNT_W)) bus ();

  parking_controller #(
    .PW_W(PW_W), .PASS_1(PASS_1), .PASS_2(PASS_2), .CAPACITY(CAPACITY),
    .CNT_W(CNT_W), .WAIT_CYCLES(WAIT_CYCLES), .BLINK_DIV(BLINK_DIV),
    .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Model: which screen the gate shows and how long it has shown it.
  typedef enum int {M_IDLE, M_WAIT, M_WRONG, M_RIGHT, M_STOP, M_FULL, M_LOCK} mstate_t;
  mstate_t    m_state;
  int         m_age;
  int         m_occ;
  int         m_fail;
  bit         m_exit_prev;
  logic       e_green;
  logic       e_red;
  logic [6:0] e_hex1;
  logic [6:0] e_hex2;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] seg(input byte ch);
    case (ch)
      "E": return 7'b0000110;
      "n": return 7'b0101011;
      "6": return 7'b0000010;
      "0": return 7'b1000000;
      "5": return 7'b0010010;
      "P": return 7'b0001100;
      "F": return 7'b0001110;
      "L": return 7'b1000111;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic show(input bit g, input bit r, input byte a, input byte b);
    e_green = g; e_red = r; e_hex1 = seg(a); e_hex2 = seg(b);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock with the inputs present at that edge.
  task automatic model_step(input bit ent, input bit ex, input logic [PW_W-1:0] p1,
                            input logic [PW_W-1:0] p2, input bit rst);
    mstate_t nxt;
    bit pulse, match, blink;
    if (rst) begin
      m_state = M_IDLE; m_age = 0; m_occ = 0; m_fail = 0; m_exit_prev = 0;
      show(0, 0, " ", " ");
      return;
    end
    pulse = ex && !m_exit_prev;
    match = (p1 == PASS_1) && (p2 == PASS_2);
    blink = ((m_age / BLINK_DIV) % 2) == 1;
    case (m_state)
      M_WAIT:  show(0, 1, "E", "n");
      M_WRONG: show(0, blink, "E", "E");
      M_RIGHT: show(blink, 0, "6", "0");
      M_STOP:  show(0, blink, "5", "P");
      M_FULL:  show(0, 1, "F", "L");
      M_LOCK:  show(0, 1, "L", "0");
      default: show(0, 0, " ", " ");
    endcase
    nxt = m_state;
    case (m_state)
      M_IDLE: begin
        if (ent && m_occ == CAPACITY) nxt = M_FULL;
        else if (ent) nxt = M_WAIT;
      end
      M_WAIT: begin
        if (m_age == WAIT_CYCLES - 1) begin
          if (match) nxt = M_RIGHT;
          else begin
            nxt = M_WRONG;
`ifdef PARKING_LOCKOUT_EN
            m_fail++;
            if (m_fail >= MAX_TRIES) nxt = M_LOCK;
`endif
          end
        end
      end
      M_WRONG: begin
`ifdef PARKING_LOCKOUT_EN
        if ((m_age + 1) % WAIT_CYCLES == 0) begin
          if (match) nxt = M_RIGHT;
          else begin
            m_fail++;
            if (m_fail >= MAX_TRIES) nxt = M_LOCK;
          end
        end
`else
        if (match) nxt = M_RIGHT;
`endif
      end
      M_RIGHT: begin
        if (ent && ex) nxt = M_STOP;
        else if (pulse) begin
          nxt = M_IDLE;
          if (m_occ < CAPACITY) m_occ++;
        end
      end
      M_STOP: if (match) nxt = M_RIGHT;
      M_FULL: if (!ent || m_occ != CAPACITY) nxt = M_IDLE;
      M_LOCK: if (m_age == LOCK_CYCLES - 1) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (pulse && m_state != M_RIGHT && m_occ > 0) m_occ--;
    if (nxt == M_RIGHT || nxt == M_IDLE) m_fail = 0;
    m_age = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
    m_exit_prev = ex;
  endtask

  // Drive one cycle of inputs, step the model on the edge, compare just after.
  task automatic tick(input bit ent, input bit ex, input logic [PW_W-1:0] p1,
                      input logic [PW_W-1:0] p2, input bit rst);
    reset               = rst;
    bus.sensor_entrance = ent;
    bus.sensor_exit     = ex;
    bus.password_1      = p1;
    bus.password_2      = p2;
    @(posedge clk);
    model_step(ent, ex, p1, p2, rst);
    #1;
    check("occupancy", 32'(bus.occupancy), 32'(m_occ));
    check("full",      32'(bus.full),      32'(m_occ == CAPACITY));
    check("green_led", 32'(bus.GREEN_LED), 32'(e_green));
    check("red_led",   32'(bus.RED_LED),   32'(e_red));
    check("hex_1",     32'(bus.HEX_1),     32'(e_hex1));
    check("hex_2",     32'(bus.HEX_2),     32'(e_hex2));
  endtask

  initial begin
    logic [PW_W-1:0] rp1, rp2;
    bit rent, rex, rrst;
    int exit_pct;

    // Reset state.
    tick(0, 0, BAD, BAD, 1);
    tick(0, 0, BAD, BAD, 1);
    check("reset_hex_1", 32'(bus.HEX_1), 32'h7F);
    check("reset_hex_2", 32'(bus.HEX_2), 32'h7F);
    check("reset_occ",   32'(bus.occupancy), 32'd0);

    // Correct password held: 4 clocks of window, RIGHT_PASS, glyphs a clock later.
    for (int i = 0; i < 5; i++) tick(1, 0, PASS_1, PASS_2, 0);
    tick(1, 0, PASS_1, PASS_2, 0);
    check("right_hex_1", 32'(bus.HEX_1), 32'b0000010);
    check("right_hex_2", 32'(bus.HEX_2), 32'b1000000);

    // Exit edge admits the car; a held exit level counts only once.
    for (int i = 0; i < 5; i++) tick(0, 1, BAD, BAD, 0);
    check("held_exit_occ", 32'(bus.occupancy), 32'd1);
    tick(0, 0, BAD, BAD, 0);

    // Wrong password, a blinking wait, then the correct value.
    for (int i = 0; i < 5; i++) tick(1, 0, BAD, BAD, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, BAD, BAD, 0);
    tick(1, 0, PASS_1, PASS_2, 0);
    tick(1, 0, PASS_1, PASS_2, 0);
    check("wrong_then_right_hex_1", 32'(bus.HEX_1), 32'b0000010);

    // Tailgate into STOP, then release with the password; no count change.
    tick(1, 1, BAD, BAD, 0);
    tick(0, 0, BAD, BAD, 0);
    check("stop_hex_1", 32'(bus.HEX_1), 32'b0010010);
    check("stop_hex_2", 32'(bus.HEX_2), 32'b0001100);
    tick(0, 0, PASS_1, PASS_2, 0);
    check("stop_occ", 32'(bus.occupancy), 32'd1);

    // Second car fills the lot; entrance then shows FULL.
    tick(0, 1, BAD, BAD, 0);
    tick(0, 0, BAD, BAD, 0);
    check("lot_full", 32'(bus.full), 32'd1);
    tick(1, 0, BAD, BAD, 0);
    tick(1, 0, BAD, BAD, 0);
    check("full_hex_1", 32'(bus.HEX_1), 32'b0001110);
    check("full_hex_2", 32'(bus.HEX_2), 32'b1000111);
    tick(1, 1, BAD, BAD, 0);
    check("full_leave_occ", 32'(bus.occupancy), 32'd1);
    tick(1, 1, BAD, BAD, 0);
    tick(0, 0, BAD, BAD, 0);
    check("full_to_idle_hex", 32'(bus.HEX_1), 32'h7F);

    // Drain below zero: saturates at 0.
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, BAD, BAD, 0);
      tick(0, 0, BAD, BAD, 0);
    end
    check("drain_occ", 32'(bus.occupancy), 32'd0);

    // Reset mid-operation clears the count.
    for (int i = 0; i < 5; i++) tick(1, 0, PASS_1, PASS_2, 0);
    tick(0, 1, BAD, BAD, 0);
    tick(1, 0, BAD, BAD, 0);
    tick(1, 0, BAD, BAD, 0);
    tick(1, 0, BAD, BAD, 1);
    check("midreset_occ", 32'(bus.occupancy), 32'd0);
    check("midreset_hex", 32'(bus.HEX_1), 32'h7F);

`ifdef PARKING_LOCKOUT_EN
    // Wrong password held through three windows, then the fixed lockout.
    tick(1, 0, BAD, BAD, 0);
    for (int i = 0; i < WAIT_CYCLES * MAX_TRIES; i++) tick(1, 0, BAD, BAD, 0);
    tick(0, 0, BAD, BAD, 0);
    check("lock_hex_1", 32'(bus.HEX_1), 32'b1000111);
    check("lock_hex_2", 32'(bus.HEX_2), 32'b1000000);
    for (int i = 0; i < LOCK_CYCLES - 1; i++) tick(0, 0, PASS_1, PASS_2, 0);
    tick(0, 0, BAD, BAD, 0);
    check("lock_release_hex", 32'(bus.HEX_1), 32'h7F);
    tick(1, 0, BAD, BAD, 0);
    for (int i = 0; i < WAIT_CYCLES * MAX_TRIES + 3; i++) tick(1, 0, BAD, BAD, 0);
    tick(1, 0, BAD, BAD, 1);
    check("lock_reset_hex", 32'(bus.HEX_1), 32'h7F);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      exit_pct = (i < 1500) ? 15 : 40;
      rent = ($urandom_range(0, 99) < 60);
      rex  = ($urandom_range(0, 99) < exit_pct);
      rrst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 1) == 1) begin
        rp1 = PASS_1; rp2 = PASS_2;
      end else begin
        rp1 = PW_W'($urandom); rp2 = PW_W'($urandom);
      end
      tick(rent, rex, rp1, rp2, rrst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
